rbcp_reg_responder: RTL and testbench
=====================================

Name: rbcp_reg_responder

Overview:
- RBCP slave register file, the responder side of the SiTCP RBCP initiator.
- Decodes single-byte RBCP write/read requests in a 16-byte window at BASE_ADDR and returns the one-cycle ack plus read data.
- Drives the DAQ command outputs: 32-bit data_number, 8-bit channel_ctrl, and a fixed-length trigger_cmd pulse.
- Sits beside the SiTCP wrapper in the clk domain.

Parameters:
- BASE_ADDR, 32'h0000_0000, window base; must be 16-byte aligned.
- TRIG_PULSE_LEN, 8'd4, trigger_cmd high time in clk cycles; valid range 1..255.
- DEVICE_ID, 8'h16, constant returned at offset 0x07.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- rbcp_we  in  1  write strobe, one-cycle pulse per request.
- rbcp_re  in  1  read strobe, one-cycle pulse per request.
- rbcp_addr  in  32  byte address, valid with the strobe.
- rbcp_wd  in  8  write data, valid with rbcp_we.
- rbcp_ack  out  1  access acknowledge, one-cycle pulse.
- rbcp_rd  out  8  read data, valid only while rbcp_ack=1, else 8'h00.
- status_in  in  8  live status byte, sampled on read.
- data_number  out  32  committed sample-count register.
- channel_ctrl  out  8  channel enable mask.
- trigger_cmd  out  1  trigger pulse.
- trigger_busy  out  1  high while the trigger pulse is active.

Behaviour:
- Reset (sys_rst=1 at a clk edge) clears:
  - rbcp_ack, rbcp_rd, trigger_cmd, trigger_busy
  - data_number=0, its shadow=0, channel_ctrl=0, scratch=0, trigger counter=0
- Reset mid-operation aborts any trigger pulse and suppresses a pending ack.
- Hit: rbcp_addr[31:4]==BASE_ADDR[31:4]; offset = rbcp_addr[3:0].
- A miss gets no ack. The initiator times out; no state changes.
- Latency: for a hit strobe in cycle N, rbcp_ack=1 and rbcp_rd are valid in cycle N+1 only. Both are registered outputs.
- Strobes on consecutive cycles are each acked on consecutive cycles. No request is dropped.
- If rbcp_we and rbcp_re are both 1: the access is a write, one ack, rbcp_rd=0.
- Register map:
  - 0x00..0x03: data_number shadow bytes, big-endian (0x00 is bits [31:24]). R/W; reads return the shadow.
    - A write to 0x03 updates the shadow low byte and copies the full shadow to data_number at the same edge.
    - Writes to 0x00..0x02 update the shadow only; data_number is unchanged.
  - 0x04: channel_ctrl, R/W. Takes effect at the write edge.
  - 0x05: trigger. Write with wd[0]=1 while idle loads the counter with TRIG_PULSE_LEN.
    - trigger_cmd and trigger_busy go high the cycle after the write, together with ack, and stay high for exactly TRIG_PULSE_LEN cycles.
    - A trigger write while busy is acked but ignored (no restart, no extension).
    - A write with wd[0]=0 is acked, no effect.
    - Read returns {7'b0, trigger_busy}.
  - 0x06: status, RO. Returns status_in sampled at the strobe edge. Writes are acked and ignored.
  - 0x07: DEVICE_ID, RO. Writes are acked and ignored.
  - 0x08: scratch, 8-bit R/W, no side effects.
  - 0x09..0x0F: acked; read returns 8'h00; writes ignored.
- Trigger counter: 8-bit down-counter. trigger_cmd = (count != 0). Decrements each cycle until 0; no wrap.
- Sampling: rbcp_addr and rbcp_wd are sampled only on strobe cycles. Values at other times are ignored.

Test Plan:
- Reset: after sys_rst, data_number=0, channel_ctrl=0, rbcp_ack=0, trigger_cmd=0. Read 0x07 -> ack 1 cycle later, rd=8'h16.
- data_number commit: write 0x00=12, 0x01=34, 0x02=56 -> data_number still 0. Write 0x03=78 -> data_number=32'h12345678 at the next edge. Read 0x01 -> rd=8'h34.
- Trigger: write 0x05=01 -> trigger_cmd high exactly 4 cycles starting the cycle after the write. A second write 0x05=01 on pulse cycle 2 -> acked, pulse still ends after 4 cycles total. Read 0x05 during the pulse -> 8'h01, after it -> 8'h00.
- Decode: read BASE+0x10 -> no ack for 10 cycles. Read 0x0C -> ack, rd=0. Write 0x06=FF -> ack, status_in read back unchanged. Write 0x08=A5 then read 0x08 -> 8'hA5.
- Back-to-back and collision: we on cycles 0, 1, 2 to 0x04 with wd=01, 02, 03 -> three acks on cycles 1..3, channel_ctrl=03. Simultaneous we+re to 0x08 with wd=5A -> single ack, rd=0, scratch=5A.
- Reset mid-pulse: sys_rst asserted on pulse cycle 2 -> trigger_cmd=0 and trigger_busy=0 the next cycle. A strobe in the reset cycle -> no ack.

Source files
------------

// File: rtl/rbcp_reg_responder.sv
// RBCP slave register file: decodes single-byte SiTCP RBCP accesses in a 16-byte
// window and drives the DAQ command outputs (sample count, channel mask, trigger pulse).
module rbcp_reg_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  TRIG_PULSE_LEN = 8'd4,
  parameter logic [7:0]  DEVICE_ID      = 8'h16
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        rbcp_we,
  input  logic        rbcp_re,
  input  logic [31:0] rbcp_addr,
  input  logic [7:0]  rbcp_wd,
  output logic        rbcp_ack,
  output logic [7:0]  rbcp_rd,
  input  logic [7:0]  status_in,
  output logic [31:0] data_number,
  output logic [7:0]  channel_ctrl,
  output logic        trigger_cmd,
  output logic        trigger_busy
);

  logic [31:0] shadow_q, shadow_d;
  logic [31:0] data_number_q, data_number_d;
  logic [7:0]  channel_ctrl_q, channel_ctrl_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [7:0]  trig_cnt_q, trig_cnt_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_q, rd_d;

  logic        hit;
  logic        is_write;
  logic        is_read;
  logic [3:0]  offset;
  logic        busy;

  assign busy = (trig_cnt_q != 8'd0);

  always_comb begin
    hit      = (rbcp_addr[31:4] == BASE_ADDR[31:4]);
    offset   = rbcp_addr[3:0];
    // A simultaneous we+re is treated purely as a write.
    is_write = hit & rbcp_we;
    is_read  = hit & rbcp_re & ~rbcp_we;

    shadow_d       = shadow_q;
    data_number_d  = data_number_q;
    channel_ctrl_d = channel_ctrl_q;
    scratch_d      = scratch_q;
    trig_cnt_d     = busy ? (trig_cnt_q - 8'd1) : 8'd0;
    ack_d          = is_write | is_read;
    rd_d           = 8'h00;

    if (is_write) begin
      case (offset)
        4'h0: shadow_d[31:24] = rbcp_wd;
        4'h1: shadow_d[23:16] = rbcp_wd;
        4'h2: shadow_d[15:8]  = rbcp_wd;
        4'h3: begin
          shadow_d[7:0] = rbcp_wd;
          data_number_d = {shadow_q[31:8], rbcp_wd};
        end
        4'h4: channel_ctrl_d = rbcp_wd;
        // Retrigger while busy is ignored so the pulse length is never extended.
        4'h5: if (rbcp_wd[0] && !busy) trig_cnt_d = TRIG_PULSE_LEN;
        4'h8: scratch_d = rbcp_wd;
        default: ;
      endcase
    end

    if (is_read) begin
      case (offset)
        4'h0: rd_d = shadow_q[31:24];
        4'h1: rd_d = shadow_q[23:16];
        4'h2: rd_d = shadow_q[15:8];
        4'h3: rd_d = shadow_q[7:0];
        4'h4: rd_d = channel_ctrl_q;
        4'h5: rd_d = {7'b0, busy};
        4'h6: rd_d = status_in;
        4'h7: rd_d = DEVICE_ID;
        4'h8: rd_d = scratch_q;
        default: rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      shadow_q       <= 32'h0;
      data_number_q  <= 32'h0;
      channel_ctrl_q <= 8'h00;
      scratch_q      <= 8'h00;
      trig_cnt_q     <= 8'h00;
      ack_q          <= 1'b0;
      rd_q           <= 8'h00;
    end else begin
      shadow_q       <= shadow_d;
      data_number_q  <= data_number_d;
      channel_ctrl_q <= channel_ctrl_d;
      scratch_q      <= scratch_d;
      trig_cnt_q     <= trig_cnt_d;
      ack_q          <= ack_d;
      rd_q           <= rd_d;
    end
  end

  assign rbcp_ack     = ack_q;
  assign rbcp_rd      = rd_q;
  assign data_number  = data_number_q;
  assign channel_ctrl = channel_ctrl_q;
  assign trigger_cmd  = busy;
  assign trigger_busy = busy;

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Randomized bench for rbcp_reg_responder, checked each cycle against a
// cycle-indexed behavioural model of the register map and trigger window.
module tb_rbcp_reg_responder;

  localparam logic [31:0] BASE     = 32'h1000_0040;
  localparam int          TRIG_LEN = 4;
  localparam logic [7:0]  DEV_ID   = 8'h16;

  logic        clk;
  logic        sys_rst;
  logic        rbcp_we;
  logic        rbcp_re;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd;
  logic        rbcp_ack;
  logic [7:0]  rbcp_rd;
  logic [7:0]  status_in;
  logic [31:0] data_number;
  logic [7:0]  channel_ctrl;
  logic        trigger_cmd;
  logic        trigger_busy;

  rbcp_reg_responder #(
    .BASE_ADDR     (BASE),
    .TRIG_PULSE_LEN(8'(TRIG_LEN)),
    .DEVICE_ID     (DEV_ID)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .rbcp_we     (rbcp_we),
    .rbcp_re     (rbcp_re),
    .rbcp_addr   (rbcp_addr),
    .rbcp_wd     (rbcp_wd),
    .rbcp_ack    (rbcp_ack),
    .rbcp_rd     (rbcp_rd),
    .status_in   (status_in),
    .data_number (data_number),
    .channel_ctrl(channel_ctrl),
    .trigger_cmd (trigger_cmd),
    .trigger_busy(trigger_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: shadow bytes in address order, committed count, and the last
  // cycle number on which the trigger pulse is high.
  logic [7:0]  m_shadow [4];
  logic [31:0] m_dn;
  logic [7:0]  m_chan;
  logic [7:0]  m_scratch;
  logic        exp_ack;
  logic [7:0]  exp_rd;
  int          trig_end;
  int          cyc;
  int          vectors;
  int          miscompares;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, advances the model, and checks all outputs
  // half a cycle after the edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic re,
                               input logic [31:0] addr, input logic [7:0] wd);
    logic [7:0] st;
    logic       hit;
    logic       busy_now;
    int         off;
    st        = 8'($urandom);
    sys_rst   = rst;
    rbcp_we   = we;
    rbcp_re   = re;
    rbcp_addr = addr;
    rbcp_wd   = wd;
    status_in = st;

    hit      = (addr[31:4] == BASE[31:4]);
    off      = int'(addr[3:0]);
    busy_now = (cyc <= trig_end);
    exp_ack  = 1'b0;
    exp_rd   = 8'h00;

    if (rst) begin
      for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
      m_dn      = 32'h0;
      m_chan    = 8'h00;
      m_scratch = 8'h00;
      trig_end  = -1;
    end else if (hit && (we || re)) begin
      exp_ack = 1'b1;
      if (we) begin
        case (off)
          0, 1, 2: m_shadow[off] = wd;
          3: begin
            m_shadow[3] = wd;
            m_dn = {m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3]};
          end
          4: m_chan = wd;
          5: if (wd[0] && !busy_now) trig_end = cyc + TRIG_LEN;
          8: m_scratch = wd;
          default: ;
        endcase
      end else begin
        case (off)
          0, 1, 2, 3: exp_rd = m_shadow[off];
          4: exp_rd = m_chan;
          5: exp_rd = {7'b0, busy_now};
          6: exp_rd = st;
          7: exp_rd = DEV_ID;
          8: exp_rd = m_scratch;
          default: exp_rd = 8'h00;
        endcase
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput("rbcp_ack",     32'(rbcp_ack),     32'(exp_ack));
    checkOutput("rbcp_rd",      32'(rbcp_rd),      32'(exp_rd));
    checkOutput("data_number",  data_number,       m_dn);
    checkOutput("channel_ctrl", 32'(channel_ctrl), 32'(m_chan));
    checkOutput("trigger_cmd",  32'(trigger_cmd),  32'(cyc <= trig_end));
    checkOutput("trigger_busy", 32'(trigger_busy), 32'(cyc <= trig_end));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'($urandom), 8'($urandom));
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    logic        r;
    int          sel;
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    trig_end    = -1;

    // Reset, then device ID readback
    applyStimulus(1'b1, 1'b0, 1'b0, BASE, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, BASE, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h7, 8'h00);
    idle(1);

    // Shadow bytes then commit on the low byte
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h0, 8'h12);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h1, 8'h34);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h2, 8'h56);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h3, 8'h78);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h1, 8'h00);
    checkOutput("commit_value", data_number, 32'h1234_5678);

    // Trigger, retrigger on pulse cycle 2, busy readback during and after
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h5, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h5, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h5, 8'h01);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h5, 8'h00);
    idle(1);

    // Decode: miss, reserved offset, RO write, scratch
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h10, 8'h00);
    idle(10);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'hC, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h6, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h6, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h8, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h8, 8'h00);

    // Back-to-back writes and a we+re collision
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h4, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h4, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h4, 8'h03);
    applyStimulus(1'b0, 1'b1, 1'b1, BASE + 32'h8, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h8, 8'h00);

    // Reset on pulse cycle 2 with a strobe in the reset cycle
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h5, 8'h01);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'h7, 8'h00);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(19));
      if (sel == 0)      a = 32'($urandom);
      else if (sel == 1) a = BASE + 32'h10;
      else               a = BASE | 32'($urandom_range(15));
      sel = int'($urandom_range(9));
      w = (sel >= 2 && sel <= 5) || sel == 9;
      r = (sel >= 6);
      applyStimulus($urandom_range(99) == 0, w, r, a, 8'($urandom));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
